// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: ofmap[o] = act(bias[o] + sum_i wt[o][i]*ifmap[i]) over one shared DRAM port.
// Optional macro FC_RELU_EN applies ReLU to each result before writeback; otherwise output is linear.
module fc_layer_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int FRAC_BITS  = 16,
  parameter int MAX_IN     = 400,
  parameter int LEN_W      = 9
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_in_len,
  input  logic [LEN_W-1:0]      cfg_out_len,
  input  logic [ADDR_WIDTH-1:0] cfg_if_base,
  input  logic [ADDR_WIDTH-1:0] cfg_wt_base,
  input  logic [ADDR_WIDTH-1:0] cfg_bs_base,
  input  logic [ADDR_WIDTH-1:0] cfg_of_base,
  output logic                  dram_rd_en,
  output logic [ADDR_WIDTH-1:0] dram_addr_rd,
  input  logic                  dram_rd_valid,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  output logic                  dram_wr_en,
  output logic [ADDR_WIDTH-1:0] dram_addr_wr,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_IF, S_MAC, S_BIAS, S_WB, S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] MAX_IN_L = LEN_W'(MAX_IN);

  state_t state_q, state_d;

  logic [LEN_W-1:0]      in_len_q, in_len_d;
  logic [LEN_W-1:0]      out_len_q, out_len_d;
  logic [LEN_W-1:0]      i_q, i_d;
  logic [LEN_W-1:0]      o_q, o_d;
  logic [ADDR_WIDTH-1:0] if_base_q, if_base_d;
  logic [ADDR_WIDTH-1:0] bs_base_q, bs_base_d;
  logic [ADDR_WIDTH-1:0] of_base_q, of_base_d;
  logic [ADDR_WIDTH-1:0] wt_ptr_q, wt_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  err_q, err_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] res_q, res_d;

  logic [DATA_WIDTH-1:0] ifbuf [MAX_IN];
  logic                  buf_we;
  logic [DATA_WIDTH-1:0] buf_rd;

  logic                  consume;
  logic                  illegal;
  logic signed [2*DATA_WIDTH-1:0] prod_full;
  logic signed [2*DATA_WIDTH-1:0] prod_sh;
  logic signed [DATA_WIDTH-1:0]   prod;
  logic signed [DATA_WIDTH-1:0]   res_raw;
  logic signed [DATA_WIDTH-1:0]   res_act;

  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      sat_add = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      sat_add = s[DATA_WIDTH-1:0];
  endfunction

  assign buf_rd  = ifbuf[i_q];
  assign consume = rd_en_q & dram_rd_valid;

  always_comb begin
    prod_full = $signed({{DATA_WIDTH{dram_rdata[DATA_WIDTH-1]}}, dram_rdata})
              * $signed({{DATA_WIDTH{buf_rd[DATA_WIDTH-1]}}, buf_rd});
    prod_sh   = prod_full >>> FRAC_BITS;
    prod      = prod_sh[DATA_WIDTH-1:0];
    res_raw   = sat_add(acc_q, dram_rdata);
`ifdef FC_RELU_EN
    res_act   = res_raw[DATA_WIDTH-1] ? '0 : res_raw;
`else
    res_act   = res_raw;
`endif
  end

  always_comb begin
    state_d   = state_q;
    in_len_d  = in_len_q;
    out_len_d = out_len_q;
    i_d       = i_q;
    o_d       = o_q;
    if_base_d = if_base_q;
    bs_base_d = bs_base_q;
    of_base_d = of_base_q;
    wt_ptr_d  = wt_ptr_q;
    acc_d     = acc_q;
    res_d     = res_q;
    err_d     = err_q;
    buf_we    = 1'b0;
    illegal   = (cfg_in_len == '0) || (cfg_out_len == '0) || (cfg_in_len > MAX_IN_L);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_len_d  = cfg_in_len;
          out_len_d = cfg_out_len;
          if_base_d = cfg_if_base;
          bs_base_d = cfg_bs_base;
          of_base_d = cfg_of_base;
          wt_ptr_d  = cfg_wt_base;
          i_d       = '0;
          o_d       = '0;
          acc_d     = '0;
          err_d     = illegal;
          state_d   = illegal ? S_DONE : S_LD_IF;
        end
      end
      S_LD_IF: begin
        if (consume) begin
          buf_we = 1'b1;
          if (i_q == in_len_q - 1'b1) begin
            i_d     = '0;
            state_d = S_MAC;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        if (consume) begin
          acc_d    = sat_add(acc_q, prod);
          wt_ptr_d = wt_ptr_q + 1'b1;
          if (i_q == in_len_q - 1'b1) begin
            i_d     = '0;
            state_d = S_BIAS;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_BIAS: begin
        if (consume) begin
          res_d   = res_act;
          state_d = S_WB;
        end
      end
      S_WB: begin
        acc_d   = '0;
        o_d     = o_q + 1'b1;
        state_d = (o_q == out_len_q - 1'b1) ? S_DONE : S_MAC;
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Request is derived from the next state so a new read can follow a consumed one back-to-back.
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_d)
      S_LD_IF: begin
        rd_en_d   = 1'b1;
        rd_addr_d = if_base_d + ADDR_WIDTH'(i_d);
      end
      S_MAC: begin
        rd_en_d   = 1'b1;
        rd_addr_d = wt_ptr_d;
      end
      S_BIAS: begin
        rd_en_d   = 1'b1;
        rd_addr_d = bs_base_d + ADDR_WIDTH'(o_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q   <= S_IDLE;
      in_len_q  <= '0;
      out_len_q <= '0;
      i_q       <= '0;
      o_q       <= '0;
      if_base_q <= '0;
      bs_base_q <= '0;
      of_base_q <= '0;
      wt_ptr_q  <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      err_q     <= 1'b0;
      acc_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_len_q  <= in_len_d;
      out_len_q <= out_len_d;
      i_q       <= i_d;
      o_q       <= o_d;
      if_base_q <= if_base_d;
      bs_base_q <= bs_base_d;
      of_base_q <= of_base_d;
      wt_ptr_q  <= wt_ptr_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      err_q     <= err_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
    end
  end

  // ifmap buffer holds no state that matters across layers, so it is left unreset.
  always_ff @(posedge clk) begin
    if (buf_we) ifbuf[i_q] <= dram_rdata;
  end

  assign dram_rd_en   = rd_en_q;
  assign dram_addr_rd = rd_addr_q;
  assign dram_wr_en   = (state_q == S_WB);
  assign dram_addr_wr = dram_wr_en ? (of_base_q + ADDR_WIDTH'(o_q)) : '0;
  assign dram_wdata   = dram_wr_en ? res_q : '0;
  assign busy         = (state_q == S_LD_IF) || (state_q == S_MAC) ||
                        (state_q == S_BIAS)  || (state_q == S_WB);
  assign done         = (state_q == S_DONE);
  assign err          = done & err_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine: DRAM responder with optional random latency, vector table and corner sequences.
module tb_fc_layer_engine;
  localparam int DW = 32;
  localparam int AW = 18;
  localparam int LW = 9;
  localparam int MAXI = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srstn, start;
  logic [LW-1:0] cfg_in_len, cfg_out_len;
  logic [AW-1:0] cfg_if_base, cfg_wt_base, cfg_bs_base, cfg_of_base;
  logic          dram_rd_en, dram_wr_en, busy, done, err;
  logic [AW-1:0] dram_addr_rd, dram_addr_wr;
  logic          dram_rd_valid = 1'b0;
  logic [DW-1:0] dram_rdata = '0;
  logic [DW-1:0] dram_wdata;

  fc_layer_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAC_BITS(16), .MAX_IN(MAXI), .LEN_W(LW)) dut (
    .clk(clk), .srstn(srstn), .start(start),
    .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len),
    .cfg_if_base(cfg_if_base), .cfg_wt_base(cfg_wt_base), .cfg_bs_base(cfg_bs_base), .cfg_of_base(cfg_of_base),
    .dram_rd_en(dram_rd_en), .dram_addr_rd(dram_addr_rd), .dram_rd_valid(dram_rd_valid), .dram_rdata(dram_rdata),
    .dram_wr_en(dram_wr_en), .dram_addr_wr(dram_addr_wr), .dram_wdata(dram_wdata),
    .busy(busy), .done(done), .err(err)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int total = 0;
  int bad = 0;

  bit rnd_lat = 0;
  bit served = 0;
  bit prev_pend = 0;
  int wait_cnt = 0;
  int lat_cur = 0;
  int stab_err = 0;
  int rd_seen = 0;
  int wr_seen = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];

  // DRAM model: answers after lat_cur waiting cycles, sprays stray valids when idle in random mode.
  always @(posedge clk) begin
    #1;
    if (srstn && prev_pend && (!dram_rd_en || dram_addr_rd != prev_addr)) stab_err++;
    if (served || !srstn) begin
      wait_cnt = 0;
      lat_cur  = rnd_lat ? int'($urandom_range(0, 5)) : 0;
    end
    served = 0;
    dram_rd_valid = 1'b0;
    if (dram_rd_en) begin
      rd_seen++;
      if (wait_cnt >= lat_cur) begin
        dram_rd_valid = 1'b1;
        dram_rdata    = mem[dram_addr_rd];
        served        = 1;
      end else begin
        wait_cnt++;
      end
    end else if (rnd_lat) begin
      dram_rd_valid = 1'($urandom_range(0, 1));
      dram_rdata    = $urandom;
    end
    if (dram_wr_en) begin
      wr_seen++;
      wr_addr_q.push_back(dram_addr_wr);
      wr_data_q.push_back(dram_wdata);
    end
    prev_pend = srstn && dram_rd_en && !dram_rd_valid;
    prev_addr = dram_addr_rd;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_start(input int in_l, input int out_l,
                          input logic [AW-1:0] ifb, input logic [AW-1:0] wtb,
                          input logic [AW-1:0] bsb, input logic [AW-1:0] ofb);
    @(negedge clk);
    cfg_in_len = LW'(in_l); cfg_out_len = LW'(out_l);
    cfg_if_base = ifb; cfg_wt_base = wtb; cfg_bs_base = bsb; cfg_of_base = ofb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output bit ok);
    int n;
    n = 0;
    ok = 0;
    while (n < budget && !ok) begin
      @(posedge clk); #2;
      if (done) ok = 1;
      n++;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: no done within %0d cycles, required done=1", name, budget);
    end
  endtask

  function automatic logic [DW-1:0] sat32(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
    return v[31:0];
  endfunction

  function automatic logic [DW-1:0] model_neuron(input int in_l, input int o, input logic [AW-1:0] ifb,
                                                 input logic [AW-1:0] wtb, input logic [AW-1:0] bsb);
    longint acc, p;
    logic [DW-1:0] x, w, r;
    logic [AW-1:0] a;
    acc = 0;
    for (int i = 0; i < in_l; i++) begin
      a = AW'(int'(ifb) + i);
      x = mem[a];
      a = AW'(int'(wtb) + o * in_l + i);
      w = mem[a];
      p = (longint'($signed(w)) * longint'($signed(x))) >>> 16;
      p = longint'($signed(p[31:0]));
      acc = longint'($signed(sat32(acc + p)));
    end
    a = AW'(int'(bsb) + o);
    r = sat32(acc + longint'($signed(mem[a])));
`ifdef FC_RELU_EN
    if (r[31]) r = '0;
`endif
    return r;
  endfunction

  typedef struct {
    string         name;
    int            in_l;
    int            out_l;
    logic [AW-1:0] ifb, wtb, bsb, ofb;
    logic [DW-1:0] x, w, b;
    logic [DW-1:0] exp_lin, exp_relu;
  } vec_t;

  vec_t vecs [9];

  task automatic check_writes(input string name, input int out_l, input logic [AW-1:0] ofb,
                              input logic [DW-1:0] exp_fixed, input bit use_model, input int in_l,
                              input logic [AW-1:0] ifb, input logic [AW-1:0] wtb, input logic [AW-1:0] bsb);
    logic [DW-1:0] e;
    logic [AW-1:0] ea;
    check($sformatf("%s_nwr", name), 64'(wr_addr_q.size()), 64'(out_l));
    for (int o = 0; o < out_l && o < wr_addr_q.size(); o++) begin
      ea = AW'(int'(ofb) + o);
      e  = use_model ? model_neuron(in_l, o, ifb, wtb, bsb) : exp_fixed;
      check($sformatf("%s_addr%0d", name, o), 64'(wr_addr_q[o]), 64'(ea));
      check($sformatf("%s_data%0d", name, o), 64'(wr_data_q[o]), 64'(e));
    end
  endtask

  initial begin
    bit ok;
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    srstn = 1'b0; start = 1'b0;
    cfg_in_len = '0; cfg_out_len = '0;
    cfg_if_base = '0; cfg_wt_base = '0; cfg_bs_base = '0; cfg_of_base = '0;

    //                name            in out  ifb       wtb      bsb      ofb      x             w             b             lin           relu
    vecs[0] = '{"basic",          1, 1, 18'h00100, 18'h00200, 18'h00300, 18'h00400, 32'h00020000, 32'h00018000, 32'h00010000, 32'h00040000, 32'h00040000};
    vecs[1] = '{"acc_sat_pos",    2, 1, 18'h00500, 18'h00600, 18'h00700, 18'h00800, 32'h7FFF0000, 32'h00010000, 32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
    vecs[2] = '{"acc_sat_neg",    2, 1, 18'h00900, 18'h00A00, 18'h00B00, 18'h00C00, 32'h80000000, 32'h00010000, 32'h00000000, 32'h80000000, 32'h00000000};
    vecs[3] = '{"neg_one",        1, 1, 18'h00D00, 18'h00E00, 18'h00F00, 18'h01000, 32'h00000000, 32'h00030000, 32'hFFFF0000, 32'hFFFF0000, 32'h00000000};
    vecs[4] = '{"prod_trunc",     1, 1, 18'h01100, 18'h01200, 18'h01300, 18'h01400, 32'h7FFF0000, 32'h7FFF0000, 32'h00000000, 32'h00010000, 32'h00010000};
    vecs[5] = '{"multi_wrap",     3, 2, 18'h3FFFE, 18'h02000, 18'h02100, 18'h3FFFF, 32'h00008000, 32'hFFFE0000, 32'h00004000, 32'hFFFD4000, 32'h00000000};
    vecs[6] = '{"bias_sat",       2, 1, 18'h02200, 18'h02300, 18'h02400, 18'h02500, 32'h7FFF0000, 32'h00010000, 32'h00010000, 32'h7FFFFFFF, 32'h7FFFFFFF};
    vecs[7] = '{"neg_lsb_shift",  1, 1, 18'h02600, 18'h02700, 18'h02800, 18'h02900, 32'hFFFFFFFF, 32'h00008000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[8] = '{"tiny_shift",     1, 1, 18'h02A00, 18'h02B00, 18'h02C00, 18'h02D00, 32'h00000001, 32'h00008000, 32'h00000005, 32'h00000005, 32'h00000005};

    repeat (3) @(posedge clk);
    #2;
    check("rst_ctl", 64'({dram_rd_en, dram_wr_en, busy, done, err}), 64'(0));
    check("rst_addr", 64'({dram_addr_rd, dram_addr_wr}), 64'(0));
    check("rst_wdata", 64'(dram_wdata), 64'(0));
    @(negedge clk);
    srstn = 1'b1;

    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].in_l; i++) mem[AW'(int'(vecs[k].ifb) + i)] = vecs[k].x;
      for (int i = 0; i < vecs[k].in_l * vecs[k].out_l; i++) mem[AW'(int'(vecs[k].wtb) + i)] = vecs[k].w;
      for (int i = 0; i < vecs[k].out_l; i++) mem[AW'(int'(vecs[k].bsb) + i)] = vecs[k].b;
      wr_addr_q.delete(); wr_data_q.delete();
      do_start(vecs[k].in_l, vecs[k].out_l, vecs[k].ifb, vecs[k].wtb, vecs[k].bsb, vecs[k].ofb);
      check($sformatf("%s_busy", vecs[k].name), 64'(busy), 64'(1));
      wait_done(vecs[k].name, 200, ok);
      check($sformatf("%s_err", vecs[k].name), 64'({busy, err}), 64'(0));
      @(posedge clk); #2;
      check($sformatf("%s_done_pulse", vecs[k].name), 64'({done, busy}), 64'(0));
`ifdef FC_RELU_EN
      e = vecs[k].exp_relu;
`else
      e = vecs[k].exp_lin;
`endif
      check_writes(vecs[k].name, vecs[k].out_l, vecs[k].ofb, e, 0, 0, '0, '0, '0);
    end

    // Random latency with stray valids, plus a start attempt while busy that must be ignored.
    for (int i = 0; i < 4; i++) mem[AW'(18'h03000 + i)] = $urandom_range(0, 32'h7FFFF) - 32'h40000;
    for (int i = 0; i < 12; i++) mem[AW'(18'h03100 + i)] = $urandom_range(0, 32'h3FFFF) - 32'h20000;
    for (int i = 0; i < 3; i++) mem[AW'(18'h03200 + i)] = $urandom_range(0, 32'h3FFFF) - 32'h20000;
    rnd_lat = 1; stab_err = 0;
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(4, 3, 18'h03000, 18'h03100, 18'h03200, 18'h03300);
    repeat (3) @(negedge clk);
    cfg_in_len = 9'd1; cfg_out_len = 9'd1;
    cfg_if_base = 18'h0; cfg_wt_base = 18'h0; cfg_bs_base = 18'h0; cfg_of_base = 18'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("rand_lat", 2000, ok);
    @(posedge clk); #2;
    rnd_lat = 0;
    check("rand_lat_addr_stable", 64'(stab_err), 64'(0));
    check_writes("rand_lat", 3, 18'h03300, '0, 1, 4, 18'h03000, 18'h03100, 18'h03200);

    // Illegal configurations: done and err together, no DRAM traffic.
    for (int t = 0; t < 3; t++) begin
      repeat (2) @(negedge clk);
      rd_seen = 0; wr_seen = 0;
      case (t)
        0: do_start(0, 1, 18'h0, 18'h0, 18'h0, 18'h0);
        1: do_start(MAXI + 1, 1, 18'h0, 18'h0, 18'h0, 18'h0);
        default: do_start(4, 0, 18'h0, 18'h0, 18'h0, 18'h0);
      endcase
      check($sformatf("illegal%0d_done_err", t), 64'({done, err, busy}), 64'(3'b110));
      repeat (5) @(posedge clk);
      #2;
      check($sformatf("illegal%0d_quiet", t), 64'({rd_seen, wr_seen}), 64'(0));
      check($sformatf("illegal%0d_idle", t), 64'({done, err, busy}), 64'(0));
    end

    // Large layer aborted by reset mid-MAC, then rerun in full.
    for (int i = 0; i < MAXI; i++) mem[AW'(18'h04000 + i)] = $urandom_range(0, 32'h3FFFF) - 32'h20000;
    for (int i = 0; i < MAXI * 120; i++) mem[AW'(18'h08000 + i)] = $urandom_range(0, 32'h7FFF) - 32'h4000;
    for (int i = 0; i < 120; i++) mem[AW'(18'h20000 + i)] = $urandom_range(0, 32'h3FFFF) - 32'h20000;
    do_start(MAXI, 120, 18'h04000, 18'h08000, 18'h20000, 18'h30000);
    repeat (1200) @(negedge clk);
    check("big_busy_before_rst", 64'(busy), 64'(1));
    srstn = 1'b0;
    @(posedge clk); #2;
    check("midrst_ctl", 64'({dram_rd_en, dram_wr_en, busy, done, err}), 64'(0));
    check("midrst_addr", 64'({dram_addr_rd, dram_addr_wr}), 64'(0));
    check("midrst_wdata", 64'(dram_wdata), 64'(0));
    repeat (2) @(negedge clk);
    srstn = 1'b1;
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(MAXI, 120, 18'h04000, 18'h08000, 18'h20000, 18'h30000);
    wait_done("big", 60000, ok);
    @(posedge clk); #2;
    check_writes("big", 120, 18'h30000, '0, 1, MAXI, 18'h04000, 18'h08000, 18'h20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
